// File: rtl/rank_filter_pkg.sv
// Shared constants for the rank filter engine: FSM state encodings and result mode selectors.
package rank_filter_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CAP   = 3'd3;
    localparam logic [2:0] S_CMP   = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    localparam logic [1:0] MODE_MEDIAN = 2'b00;
    localparam logic [1:0] MODE_MIN    = 2'b01;
    localparam logic [1:0] MODE_MAX    = 2'b10;
    localparam logic [1:0] MODE_RANK   = 2'b11;

endpackage

// File: rtl/rank_sort_array.sv
// Window register array: sample capture port, one compare-exchange per cycle, all entries tapped.
module rank_sort_array #(
    parameter int D_WIDTH = 8,
    parameter int R_WIDTH = 3
) (
    input  logic                                Clk,
    input  logic                                Rst,
    input  logic                                wr_en,
    input  logic [R_WIDTH-1:0]                  wr_idx,
    input  logic [D_WIDTH-1:0]                  wr_data,
    input  logic                                cx_en,
    input  logic [R_WIDTH-1:0]                  cx_l,
    input  logic [R_WIDTH-1:0]                  cx_k,
    output logic [2**R_WIDTH-1:0][D_WIDTH-1:0]  taps
);

    localparam int N = 2**R_WIDTH;

    logic [N-1:0][D_WIDTH-1:0] arr_q;

    // Unsigned compare; the swap happens in the same cycle the pair is examined.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            arr_q <= '0;
        end else if (wr_en) begin
            arr_q[wr_idx] <= wr_data;
        end else if (cx_en && (arr_q[cx_l] > arr_q[cx_k])) begin
            arr_q[cx_l] <= arr_q[cx_k];
            arr_q[cx_k] <= arr_q[cx_l];
        end
    end

    assign taps = arr_q;

endmodule

// File: rtl/rank_filter_engine.sv
// Block rank filter: reads N-sample windows from memory A, sorts each in place and writes
// one rank statistic (median/min/max/rank-k) per window to the result memory.
module rank_filter_engine
    import rank_filter_pkg::*;
#(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 8,
    parameter int R_WIDTH = 3,
    parameter int RD_LAT  = 2
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Go,
    input  logic [1:0]                 Mode,
    input  logic [R_WIDTH-1:0]         Rank,
    output logic [A_WIDTH-1:0]         A_Addr,
    input  logic [D_WIDTH-1:0]         A_Data,
    output logic                       A_RW,
    output logic                       A_EN,
    output logic [A_WIDTH-R_WIDTH-1:0] Out_Addr,
    output logic [D_WIDTH-1:0]         Out_Data,
    output logic                       Out_RW,
    output logic                       Out_EN,
    output logic                       Busy,
    output logic                       Done
);

    localparam int N     = 2**R_WIDTH;
    localparam int J_W   = A_WIDTH - R_WIDTH;
    localparam int WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

    logic [2:0]           state_q;
    logic [1:0]           mode_q;
    logic [R_WIDTH-1:0]   rank_q;
    logic [A_WIDTH-1:0]   i_q;
    logic [J_W-1:0]       j_q;
    logic [R_WIDTH-1:0]   m_q;
    logic [R_WIDTH-1:0]   l_q;
    logic [R_WIDTH-1:0]   k_q;
    logic [WAIT_W-1:0]    wait_q;

    logic [N-1:0][D_WIDTH-1:0] taps;
    logic [D_WIDTH:0]          median_sum;
    logic [D_WIDTH-1:0]        result;

    rank_sort_array #(
        .D_WIDTH (D_WIDTH),
        .R_WIDTH (R_WIDTH)
    ) u_sort (
        .Clk     (Clk),
        .Rst     (Rst),
        .wr_en   (state_q == S_CAP),
        .wr_idx  (m_q),
        .wr_data (A_Data),
        .cx_en   (state_q == S_CMP),
        .cx_l    (l_q),
        .cx_k    (k_q),
        .taps    (taps)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            rank_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            m_q     <= '0;
            l_q     <= '0;
            k_q     <= '0;
            wait_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Go) begin
                        mode_q  <= Mode;
                        rank_q  <= Rank;
                        i_q     <= '0;
                        j_q     <= '0;
                        m_q     <= '0;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    wait_q  <= '0;
                    state_q <= (RD_LAT > 1) ? S_WAIT : S_CAP;
                end
                S_WAIT: begin
                    if (wait_q == WAIT_W'(RD_LAT - 2)) state_q <= S_CAP;
                    else wait_q <= wait_q + 1'b1;
                end
                S_CAP: begin
                    m_q <= m_q + 1'b1;
                    i_q <= i_q + 1'b1;
                    if (m_q == R_WIDTH'(N - 1)) begin
                        l_q     <= '0;
                        k_q     <= R_WIDTH'(1);
                        state_q <= S_CMP;
                    end else begin
                        state_q <= S_REQ;
                    end
                end
                S_CMP: begin
                    if (k_q == R_WIDTH'(N - 1)) begin
                        // Final pair (N-2, N-1) closes the N(N-1)/2 sweep.
                        if (l_q == R_WIDTH'(N - 2)) state_q <= S_WRITE;
                        l_q <= l_q + 1'b1;
                        k_q <= l_q + R_WIDTH'(2);
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    j_q     <= j_q + 1'b1;
                    m_q     <= '0;
                    state_q <= (j_q == {J_W{1'b1}}) ? S_FIN : S_REQ;
                end
                S_FIN:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Extra carry bit keeps the two-sample sum from wrapping before the halving shift.
    always_comb begin
        median_sum = {1'b0, taps[N/2-1]} + {1'b0, taps[N/2]};
        result     = '0;
        case (mode_q)
            MODE_MEDIAN: result = median_sum[D_WIDTH:1];
            MODE_MIN:    result = taps[0];
            MODE_MAX:    result = taps[N-1];
            MODE_RANK:   result = taps[rank_q];
            default:     result = '0;
        endcase
    end

    always_comb begin
        A_RW     = 1'b0;
        A_EN     = (state_q == S_REQ);
        A_Addr   = (state_q == S_REQ) ? i_q : '0;
        Out_EN   = (state_q == S_WRITE);
        Out_RW   = (state_q == S_WRITE);
        Out_Addr = (state_q == S_WRITE) ? j_q : '0;
        Out_Data = (state_q == S_WRITE) ? result : '0;
        Done     = (state_q == S_FIN);
        Busy     = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_rank_filter_engine.sv
// Scoreboard bench for rank_filter_engine: expected window results queued at start, popped on Out_EN.
module tb_rank_filter_engine;

    localparam int DW       = 8;
    localparam int AW       = 8;
    localparam int RW       = 3;
    localparam int RL       = 2;
    localparam int N        = 8;
    localparam int NW       = 32;
    localparam int WIN_CYC  = N * (RL + 1) + N * (N - 1) / 2 + 1;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Go;
    logic [1:0]    Mode;
    logic [RW-1:0] Rank;
    logic [AW-1:0] A_Addr;
    logic [DW-1:0] A_Data;
    logic          A_RW;
    logic          A_EN;
    logic [AW-RW-1:0] Out_Addr;
    logic [DW-1:0] Out_Data;
    logic          Out_RW;
    logic          Out_EN;
    logic          Busy;
    logic          Done;

    rank_filter_engine #(
        .D_WIDTH (DW),
        .A_WIDTH (AW),
        .R_WIDTH (RW),
        .RD_LAT  (RL)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Go       (Go),
        .Mode     (Mode),
        .Rank     (Rank),
        .A_Addr   (A_Addr),
        .A_Data   (A_Data),
        .A_RW     (A_RW),
        .A_EN     (A_EN),
        .Out_Addr (Out_Addr),
        .Out_Data (Out_Data),
        .Out_RW   (Out_RW),
        .Out_EN   (Out_EN),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 Clk = ~Clk;

    // Memory A model with RL-cycle read pipeline.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rd_pipe [RL];

    always @(posedge Clk) begin
        if (A_EN) rd_pipe[0] <= mem[A_Addr];
        for (int p = 1; p < RL; p++) rd_pipe[p] <= rd_pipe[p-1];
    end
    assign A_Data = rd_pipe[RL-1];

    typedef struct packed {
        logic [AW-RW-1:0] addr;
        logic [DW-1:0]    data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model(input int j, input logic [1:0] md, input int rk);
        int s[N];
        int t;
        for (int i = 0; i < N; i++) s[i] = int'(mem[j*N+i]);
        for (int a = 0; a < N - 1; a++)
            for (int b = 0; b < N - 1 - a; b++)
                if (s[b] > s[b+1]) begin
                    t = s[b]; s[b] = s[b+1]; s[b+1] = t;
                end
        case (md)
            2'b00:   return DW'((s[N/2-1] + s[N/2]) / 2);
            2'b01:   return DW'(s[0]);
            2'b10:   return DW'(s[N-1]);
            default: return DW'(s[rk]);
        endcase
    endfunction

    task automatic push_exp(input int j, input int val);
        exp_t e;
        e.addr = (AW-RW)'(j);
        e.data = DW'(val);
        sb.push_back(e);
    endtask

    task automatic push_model(input int from_j, input logic [1:0] md, input int rk);
        for (int j = from_j; j < NW; j++) push_exp(j, int'(model(j, md, rk)));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"},     Busy,     0);
        check_eq({tag, "_a_en"},     A_EN,     0);
        check_eq({tag, "_a_addr"},   A_Addr,   0);
        check_eq({tag, "_a_rw"},     A_RW,     0);
        check_eq({tag, "_out_en"},   Out_EN,   0);
        check_eq({tag, "_out_rw"},   Out_RW,   0);
        check_eq({tag, "_out_addr"}, Out_Addr, 0);
        check_eq({tag, "_out_data"}, Out_Data, 0);
        check_eq({tag, "_done"},     Done,     0);
    endtask

    // glitch_at: cycle to re-pulse Go with inverted Mode/Rank; rst_at: cycle to assert Rst.
    task automatic run_frame(input logic [1:0] md, input logic [RW-1:0] rk, input int glitch_at,
                             input int rst_at, input string tag);
        int   cyc      = 0;
        int   n_wr     = 0;
        int   first_wr = -1;
        int   done_cyc = -1;
        int   stray    = 0;
        bit   aborted  = 1'b0;
        exp_t e;
        @(negedge Clk);
        Mode = md;
        Rank = rk;
        Go   = 1'b1;
        while (cyc < 2000 && done_cyc < 0 && !aborted) begin
            @(negedge Clk);
            cyc++;
            Go = 1'b0;
            if (cyc == 1) check_eq({tag, "_busy_start"}, Busy, 1);
            if (A_EN) check_eq({tag, "_a_rw"}, A_RW, 0);
            if (Out_EN) begin
                n_wr++;
                if (first_wr < 0) first_wr = cyc;
                check_eq({tag, "_out_rw"}, Out_RW, 1);
                check_eq({tag, "_sb_nonempty"}, sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq({tag, "_out_addr"}, Out_Addr, e.addr);
                    check_eq({tag, "_out_data"}, Out_Data, e.data);
                end
            end
            if (Done) done_cyc = cyc;
            if (cyc == glitch_at) begin
                Go   = 1'b1;
                Mode = ~md;
                Rank = ~rk;
            end
            if (cyc == rst_at) begin
                Rst     = 1'b1;
                aborted = 1'b1;
            end
        end
        if (aborted) begin
            @(negedge Clk);
            Rst = 1'b0;
            check_idle_outputs({tag, "_post_rst"});
            check_eq({tag, "_writes_before_rst"}, n_wr, 5);
            repeat (100) begin
                @(negedge Clk);
                if (Out_EN || A_EN || Busy) stray++;
            end
            check_eq({tag, "_no_activity"}, stray, 0);
            sb.delete();
        end else begin
            check_eq({tag, "_first_write_cyc"}, first_wr, WIN_CYC);
            check_eq({tag, "_done_cyc"}, done_cyc, NW * WIN_CYC + 1);
            check_eq({tag, "_n_writes"}, n_wr, NW);
            check_eq({tag, "_sb_left"}, sb.size(), 0);
            @(negedge Clk);
            check_eq({tag, "_busy_after"}, Busy, 0);
            check_eq({tag, "_done_after"}, Done, 0);
            sb.delete();
        end
    endtask

    initial begin
        Rst  = 1'b1;
        Go   = 1'b0;
        Mode = 2'b00;
        Rank = '0;
        for (int i = 0; i < 256; i++) mem[i] = DW'(i);
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        check_idle_outputs("reset");

        // Ramp, median: each window's middle pair is 8j+3, 8j+4.
        for (int j = 0; j < NW; j++) push_exp(j, 8 * j + 3);
        run_frame(2'b00, 3'd0, -1, -1, "ramp_med");

        // Reversed block at window 0 under min/max/rank-5.
        for (int i = 0; i < N; i++) mem[i] = DW'(250 - i);
        push_exp(0, 243); push_model(1, 2'b01, 5);
        run_frame(2'b01, 3'd5, -1, -1, "rev_min");
        push_exp(0, 250); push_model(1, 2'b10, 5);
        run_frame(2'b10, 3'd5, -1, -1, "rev_max");
        push_exp(0, 248); push_model(1, 2'b11, 5);
        run_frame(2'b11, 3'd5, -1, -1, "rev_rank5");

        // Saturated window: median sum must not wrap.
        for (int i = 0; i < N; i++) mem[i] = 8'hFF;
        push_exp(0, 255); push_model(1, 2'b00, 0);
        run_frame(2'b00, 3'd0, -1, -1, "sat_med");

        // Reset during window 5 compare phase, then a clean rerun.
        for (int i = 0; i < N; i++) mem[i] = DW'(i);
        push_model(0, 2'b00, 0);
        run_frame(2'b00, 3'd0, -1, 5 * WIN_CYC + 1 + N * (RL + 1) + 10, "abort");
        push_model(0, 2'b00, 0);
        run_frame(2'b00, 3'd0, -1, -1, "rerun");

        // Random data, rank-2, with a Go/Mode glitch mid-run.
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom_range(0, 255));
        push_model(0, 2'b11, 2);
        run_frame(2'b11, 3'd2, 150, -1, "glitch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
